sram_axi_bridge: RTL

//  Converts the core's two SRAM-like ports (inst, data) into one AXI4 master.

---
 rtl/sram_axi_bridge_pkg.sv | 26 ++
 rtl/sram_axi_bridge.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and AXI field constants for the SRAM-to-AXI bridge.
package sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_RD   = 3'd2,
    S_AWW  = 3'd3,
    S_WB   = 3'd4
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [7:0] AXI_LEN0  = 8'd0;
  localparam logic [2:0] AXI_SIZE4 = 3'd2;
  localparam logic [1:0] AXI_INCR  = 2'b01;
  localparam logic [1:0] AXI_OKAY  = 2'b00;

  function automatic logic is_store(input logic [3:0] wen);
    return |wen;
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data SRAM-style ports onto one AXI4 master,
// one single-beat transaction in flight at a time, data port first.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        fetch_stall,
  input  logic        longest_stall_f,

  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        memory_stall,
  input  logic        longest_stall_m,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,

  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_ok_q, aw_ok_d;
  logic        w_ok_q, w_ok_d;
  logic        arvalid_q, arvalid_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        rready_q, rready_d;
  logic        bready_q, bready_d;
  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic data_rd_req, data_wr_req, inst_req;
  logic aw_hs, w_hs;
  logic rd_fin, wr_fin;

  // Response IDs and codes are not checked; errors are not reported upstream.
  logic unused_axi;
  assign unused_axi = ^{rid, rresp, rlast, bid, bresp};

  assign data_rd_req = data_sram_en & ~is_store(data_sram_wen) & ~data_done_q;
  assign data_wr_req = data_sram_en &  is_store(data_sram_wen) & ~data_done_q;
  assign inst_req    = inst_sram_en & ~inst_done_q;
  assign aw_hs       = awvalid_q & awready;
  assign w_hs        = wvalid_q & wready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    id_d         = id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_ok_d      = aw_ok_q;
    w_ok_d       = w_ok_q;
    rd_fin       = 1'b0;
    wr_fin       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_rd_req) begin
          state_d = S_AR;
          owner_d = OWN_DATA;
          id_d    = DATA_ID;
          addr_d  = data_sram_addr;
        end else if (data_wr_req) begin
          state_d = S_AWW;
          owner_d = OWN_DATA;
          id_d    = DATA_ID;
          addr_d  = data_sram_addr;
          wdata_d = data_sram_wdata;
          wstrb_d = data_sram_wen;
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
        end else if (inst_req) begin
          state_d = S_AR;
          owner_d = OWN_INST;
          id_d    = INST_ID;
          addr_d  = inst_sram_addr;
        end
      end
      S_AR: begin
        if (arvalid_q && arready) state_d = S_RD;
      end
      S_RD: begin
        if (rvalid) begin
          state_d = S_IDLE;
          rd_fin  = 1'b1;
        end
      end
      S_AWW: begin
        // AW and W may complete in either order or together.
        aw_ok_d = aw_ok_q | aw_hs;
        w_ok_d  = w_ok_q | w_hs;
        if (aw_ok_d && w_ok_d) state_d = S_WB;
      end
      S_WB: begin
        if (bvalid) begin
          state_d = S_IDLE;
          wr_fin  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Channel valids/readies are decoded from the next state so they leave flops.
  always_comb begin
    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_RD);
    bready_d  = (state_d == S_WB);
    awvalid_d = (state_d == S_AWW) & ~aw_ok_d;
    wvalid_d  = (state_d == S_AWW) & ~w_ok_d;
  end

  // A result is only delivered if its requester is still asking (not flushed).
  always_comb begin
    inst_done_d  = inst_done_q;
    data_done_d  = data_done_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    if (rd_fin && owner_q == OWN_INST && inst_sram_en) begin
      inst_done_d  = 1'b1;
      inst_rdata_d = rdata;
    end else if (inst_done_q && !longest_stall_f) begin
      inst_done_d = 1'b0;
    end

    if ((rd_fin || wr_fin) && owner_q == OWN_DATA && data_sram_en) begin
      data_done_d = 1'b1;
      if (rd_fin) data_rdata_d = rdata;
    end else if (data_done_q && !longest_stall_m) begin
      data_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      id_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_ok_q      <= 1'b0;
      w_ok_q       <= 1'b0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      rready_q     <= 1'b0;
      bready_q     <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_ok_q      <= aw_ok_d;
      w_ok_q       <= w_ok_d;
      arvalid_q    <= arvalid_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      rready_q     <= rready_d;
      bready_q     <= bready_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign fetch_stall     = inst_sram_en & ~inst_done_q;
  assign memory_stall    = data_sram_en & ~data_done_q;
  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN0;
  assign arsize  = AXI_SIZE4;
  assign arburst = AXI_INCR;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN0;
  assign awsize  = AXI_SIZE4;
  assign awburst = AXI_INCR;
  assign awvalid = awvalid_q;

  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule
